stream_demux2: RTL and testbench
================================

STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 Parameter DATA_W, default 3, payload width.
REQ-002 Parameter CNT_W, default 4, per-port delivery counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  DATA_W  payload offered by upstream.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  block accepts payload this cycle.
REQ-008 a, b, c  input  1 each  routing controls; internal sel = (a & b) | c.
REQ-009 out1_data, out2_data  output  DATA_W each  delivered payload, port 1 / port 2.
REQ-010 out1_valid, out2_valid  output  1 each  port holds a payload.
REQ-011 out1_ready, out2_ready  input  1 each  downstream takes payload.
REQ-012 cnt1, cnt2  output  CNT_W each  count of completed deliveries per port.
REQ-013 busy  output  1  = out1_valid | out2_valid.

Function
REQ-014 Acceptance occurs in a cycle where in_valid & in_ready; sel is sampled only in that cycle.
REQ-015 Accepted payload SHALL route to port 1 when sel = 1, otherwise to port 2.
REQ-016 Each port SHALL hold one payload in a two-state slot: EMPTY, FULL.
REQ-017 Slot EMPTY -> FULL on acceptance targeting it; FULL -> EMPTY on outN_valid & outN_ready with no same-cycle acceptance to it; FULL -> FULL with new payload on simultaneous drain and acceptance.
REQ-018 in_ready SHALL be 1 when the slot selected by current sel is EMPTY, or FULL with its outN_ready = 1; in_ready SHALL NOT depend on in_valid.
REQ-019 Latency: accepted payload SHALL appear on outN_data with outN_valid = 1 in the cycle after acceptance.
REQ-020 outN_data SHALL remain stable while outN_valid & !outN_ready.
REQ-021 The non-selected slot SHALL be unaffected by acceptance; both slots may be FULL simultaneously.
REQ-022 A change of a/b/c while in_valid is held but not accepted SHALL redirect the pending payload to the port selected at acceptance.
REQ-023 cntN SHALL increment by 1 on each outN_valid & outN_ready and wrap from 2^CNT_W-1 to 0.
REQ-024 outN_data SHALL retain the last delivered value when the slot goes EMPTY.
REQ-025 No payload SHALL be duplicated, dropped or reordered within a port.

Reset
REQ-026 While rst = 1: both slots EMPTY, out1_valid = out2_valid = 0, out1_data = out2_data = 0, cnt1 = cnt2 = 0, busy = 0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 Reset asserted mid-operation SHALL discard buffered payloads immediately, without waiting for a clock edge.

Structure
REQ-029 Package stream_demux2_pkg SHALL hold typedef slot_state_e {EMPTY, FULL} and default constants DATA_W_DEF = 3, CNT_W_DEF = 4.
REQ-030 Sub-module out_slot (one-entry slot with state, data register and delivery counter) SHALL be instantiated twice.
REQ-031 Top level SHALL contain only sel decode, in_ready mux and busy.

Verification
REQ-032 in_data=3'b101, a=1,b=1,c=0, in_valid pulse, out1_ready=1 -> out1_valid=1 with 3'b101 next cycle, cnt1=1, out2_valid stays 0.
REQ-033 a=b=c=0, out2_ready=0, send 3'b011 then 3'b110 -> first accepted, in_ready=0 for second until out2_ready=1, then 3'b011 then 3'b110 delivered in order.
REQ-034 Port 1 FULL with out1_ready=1, new payload 3'b111 to port 1 same cycle -> in_ready=1, slot stays FULL, out1_data=3'b111 next cycle.
REQ-035 With CNT_W=4, 17 deliveries to port 2 -> cnt2=1, cnt1=0.
REQ-036 Both slots FULL, rst pulsed between clock edges -> out1_valid=out2_valid=0, cnt1=cnt2=0, busy=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/stream_demux2_pkg.sv
// Shared types and defaults for the two-way stream demultiplexer.
package stream_demux2_pkg;

    localparam int unsigned DATA_W_DEF = 3;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Routing select: port 1 when set, port 2 otherwise.
    function automatic logic sel_decode(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/stream_demux2_out_slot.sv
// One-entry output slot: holds a payload, presents it downstream and counts deliveries.
module out_slot
    import stream_demux2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  cnt
);

    slot_state_e state;

    assign valid = (state == FULL);

    // Data register keeps the last delivered value once the slot drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state <= FULL;
                        data  <= load_data;
                    end
                end
                FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (state == FULL && ready) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// Two-way stream demultiplexer: routes each accepted payload to one of two one-entry slots.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic              busy
);

    logic sel;
    logic load1;
    logic load2;

    assign sel = sel_decode(a, b, c);

    // A slot can take a payload when empty or when it drains in the same cycle.
    assign in_ready = sel ? (!out1_valid || out1_ready) : (!out2_valid || out2_ready);

    assign load1 = in_valid & in_ready & sel;
    assign load2 = in_valid & in_ready & !sel;
    assign busy  = out1_valid | out2_valid;

    out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .cnt       (cnt1)
    );

    out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot2 (
        .clk       (clk),
        .rst       (rst),
        .load      (load2),
        .load_data (in_data),
        .ready     (out2_ready),
        .valid     (out2_valid),
        .data      (out2_data),
        .cnt       (cnt2)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: directed vector table, corner sequences, random vs. queue model.
module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       a, b, c;
    logic [2:0] out1_data, out2_data;
    logic       out1_valid, out2_valid;
    logic       out1_ready, out2_ready;
    logic [3:0] cnt1, cnt2;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_demux2 #(.DATA_W(3), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .busy       (busy)
    );

    typedef struct {
        logic       rst;
        logic [2:0] din;
        logic       vld;
        logic       a, b, c;
        logic       r1, r2;
        logic       e_ir;
        logic       e_v1;
        logic [2:0] e_d1;
        logic       e_v2;
        logic [2:0] e_d2;
        logic [3:0] e_c1;
        logic [3:0] e_c2;
    } vec_t;

    vec_t vecs[15];

    // Reference model: per-port FIFO of at most one payload, last delivered value, delivery count.
    logic [2:0] q1[$];
    logic [2:0] q2[$];
    int last1, last2, mc1, mc2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        last1 = 0;
        last2 = 0;
        mc1 = 0;
        mc2 = 0;
    endtask

    function automatic int model_ready();
        int to_port1;
        to_port1 = int'((a & b) | c);
        if (to_port1 != 0) return int'(q1.size() == 0 || out1_ready);
        return int'(q2.size() == 0 || out2_ready);
    endfunction

    task automatic model_check(input string tag);
        int e_v1, e_v2, e_d1, e_d2;
        if (rst) model_clear();
        e_v1 = int'(q1.size() != 0);
        e_v2 = int'(q2.size() != 0);
        e_d1 = (q1.size() != 0) ? int'(q1[0]) : last1;
        e_d2 = (q2.size() != 0) ? int'(q2[0]) : last2;
        chk({tag, ".in_ready"}, int'(in_ready), model_ready());
        chk({tag, ".out1_valid"}, int'(out1_valid), e_v1);
        chk({tag, ".out2_valid"}, int'(out2_valid), e_v2);
        if (e_v1 != 0) chk({tag, ".out1_data"}, int'(out1_data), e_d1);
        if (e_v2 != 0) chk({tag, ".out2_data"}, int'(out2_data), e_d2);
        chk({tag, ".cnt1"}, int'(cnt1), mc1);
        chk({tag, ".cnt2"}, int'(cnt2), mc2);
        chk({tag, ".busy"}, int'(busy), int'(e_v1 != 0 || e_v2 != 0));
    endtask

    task automatic model_update();
        int acc, to_port1;
        if (rst) begin
            model_clear();
            return;
        end
        to_port1 = int'((a & b) | c);
        acc = int'(in_valid) & model_ready();
        if (q1.size() != 0 && out1_ready) begin
            last1 = int'(q1.pop_front());
            mc1 = (mc1 + 1) % 16;
        end
        if (q2.size() != 0 && out2_ready) begin
            last2 = int'(q2.pop_front());
            mc2 = (mc2 + 1) % 16;
        end
        if (acc != 0) begin
            if (to_port1 != 0) q1.push_back(in_data);
            else q2.push_back(in_data);
        end
    endtask

    // Check at the falling edge, advance model, then step past the rising edge.
    task automatic model_step(input string tag);
        @(negedge clk);
        model_check(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic [2:0] d, input logic v,
                          input logic ia, input logic ib, input logic ic,
                          input logic r1, input logic r2);
        rst = r; in_data = d; in_valid = v;
        a = ia; b = ib; c = ic;
        out1_ready = r1; out2_ready = r2;
    endtask

    initial begin
        set_in(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();

        //          rst din  vld a  b  c  r1 r2   ir v1 d1 v2 d2 c1 c2
        vecs[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 4'd0};
        vecs[1]  = '{1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 4'd0};
        vecs[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 4'd0, 4'd0};
        vecs[3]  = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd0, 4'd1, 4'd0};
        vecs[4]  = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd3, 4'd1, 4'd0};
        vecs[5]  = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd3, 4'd1, 4'd0};
        vecs[6]  = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 3'd3, 4'd1, 4'd0};
        vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd6, 4'd1, 4'd1};
        vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 3'd6, 4'd1, 4'd1};
        vecs[9]  = '{1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd6, 4'd1, 4'd2};
        vecs[10] = '{1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 3'd6, 4'd1, 4'd2};
        vecs[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd6, 4'd2, 4'd2};
        vecs[12] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 3'd6, 4'd2, 4'd2};
        vecs[13] = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd6, 4'd2, 4'd2};
        vecs[14] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 3'd4, 4'd2, 4'd2};

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            set_in(vecs[i].rst, vecs[i].din, vecs[i].vld, vecs[i].a, vecs[i].b, vecs[i].c,
                   vecs[i].r1, vecs[i].r2);
            @(negedge clk);
            chk({t, ".in_ready"}, int'(in_ready), int'(vecs[i].e_ir));
            chk({t, ".out1_valid"}, int'(out1_valid), int'(vecs[i].e_v1));
            chk({t, ".out1_data"}, int'(out1_data), int'(vecs[i].e_d1));
            chk({t, ".out2_valid"}, int'(out2_valid), int'(vecs[i].e_v2));
            chk({t, ".out2_data"}, int'(out2_data), int'(vecs[i].e_d2));
            chk({t, ".cnt1"}, int'(cnt1), int'(vecs[i].e_c1));
            chk({t, ".cnt2"}, int'(cnt2), int'(vecs[i].e_c2));
            chk({t, ".busy"}, int'(busy), int'(vecs[i].e_v1 | vecs[i].e_v2));
            @(posedge clk);
            #1;
        end

        // Both slots full here: asynchronous reset must clear everything without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out1_valid", int'(out1_valid), 0);
        chk("arst.out2_valid", int'(out2_valid), 0);
        chk("arst.out1_data", int'(out1_data), 0);
        chk("arst.out2_data", int'(out2_data), 0);
        chk("arst.cnt1", int'(cnt1), 0);
        chk("arst.cnt2", int'(cnt2), 0);
        chk("arst.busy", int'(busy), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.in_ready_after", int'(in_ready), 1);
        model_clear();

        // Counter wrap: 17 deliveries to port 2.
        for (int i = 0; i < 17; i++) begin
            set_in(1'b0, 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            model_step("wrap");
        end
        set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_step("wrap");
        @(negedge clk);
        chk("wrap.cnt2", int'(cnt2), 1);
        chk("wrap.cnt1", int'(cnt1), 0);
        @(posedge clk);
        #1;

        // Random traffic against the queue model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 99) == 0), 3'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
            model_step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
